// File: rtl/count_serial_tx_pkg.sv
// Shared types and sizing helpers for the count_serial_tx slice.
// TX_PARITY_EN appends an even-parity bit to every serial frame.
package count_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_t;

`ifdef TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int nbits(input int width);
    return width + PARITY_BITS;
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_shift_tx.sv
// Frame/clock/data serial transmitter: FSM, bit-period divider and shift register.
// With TX_PARITY_EN defined, even parity of the snapshot follows the LSB.
module serial_shift_tx
  import count_serial_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tx_start,
  input  logic [WIDTH-1:0] data,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             ser_frame,
  output logic             ser_clk,
  output logic             ser_data
);

  localparam int NBITS = nbits(WIDTH);
  localparam int IDX_W = idx_width(NBITS);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

  tx_state_t        state;
  logic [NBITS-1:0] snap;
  logic [NBITS-2:0] shreg;
  logic [IDX_W-1:0] bit_idx;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

`ifdef TX_PARITY_EN
  assign snap = {data, ^data};
`else
  assign snap = data;
`endif

  assign div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  assign tx_busy = (state != IDLE);

  // ser_data holds the bit on the wire; shreg holds the bits still to come.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      div       <= '0;
      tx_done   <= 1'b0;
      ser_frame <= 1'b0;
      ser_clk   <= 1'b0;
      ser_data  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (tx_start) begin
            state     <= SHIFT;
            shreg     <= snap[NBITS-2:0];
            bit_idx   <= '0;
            div       <= '0;
            ser_frame <= 1'b1;
            ser_clk   <= 1'b0;
            ser_data  <= snap[NBITS-1];
          end
        end
        SHIFT: begin
          div <= div_nxt;
          if (div == DIV_LAST) begin
            ser_clk <= 1'b0;
            if (bit_idx == IDX_LAST) begin
              state     <= DONE;
              tx_done   <= 1'b1;
              ser_frame <= 1'b0;
              ser_data  <= 1'b0;
            end else begin
              shreg    <= shreg << 1;
              bit_idx  <= bit_idx + IDX_W'(1);
              ser_data <= shreg[NBITS-2];
            end
          end else begin
            ser_clk <= (div_nxt >= DIV_HALF);
          end
        end
        DONE: begin
          state   <= IDLE;
          tx_done <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/count_serial_tx.sv
// Loadable up/down counter whose value can be snapshotted onto a 3-wire serial link.
// TX_PARITY_EN (see serial_shift_tx) adds a parity bit to each frame.
module count_serial_tx
  import count_serial_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  input  logic             tx_start,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             ser_frame,
  output logic             ser_clk,
  output logic             ser_data
);

  // Load wins over counting; arithmetic wraps modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (load) begin
        count <= load_val;
      end else if (cnt_en) begin
        count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  // The transmitter sees the registered count, i.e. the value before this edge's update.
  serial_shift_tx #(
    .WIDTH  (WIDTH),
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .tx_start (tx_start),
    .data     (count),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .ser_frame(ser_frame),
    .ser_clk  (ser_clk),
    .ser_data (ser_data)
  );

endmodule

// File: tb/tb_count_serial_tx.sv
// Directed self-checking bench for count_serial_tx (WIDTH=8, CLK_DIV=4).
// Define TX_PARITY_EN for both RTL and bench to exercise the parity frame.
module tb_count_serial_tx;

`ifdef TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FL = NB * 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, cnt_en, up_dn, load, tx_start;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tx_busy, tx_done, ser_frame, ser_clk, ser_data;

  int checks   = 0;
  int failures = 0;

  count_serial_tx #(.WIDTH(8), .CLK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .cnt_en   (cnt_en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .ser_frame(ser_frame),
    .ser_clk  (ser_clk),
    .ser_data (ser_data)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] frame_of(input logic [7:0] v);
`ifdef TX_PARITY_EN
    return {v, ^v};
`else
    return v;
`endif
  endfunction

  // Expected {ser_frame, tx_busy, tx_done, ser_clk, ser_data} in the cycle after edge E0+k.
  function automatic logic [4:0] ser_exp(input logic [NB-1:0] fr, input int k);
    if (k < FL) return {1'b1, 1'b1, 1'b0, (k % 4) >= 2, fr[NB-1-k/4]};
    if (k == FL) return 5'b01100;
    return 5'b00000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; cnt_en = 1'b0; up_dn = 1'b0;
    load = 1'b1; load_val = 8'hFF; tx_start = 1'b1;
    repeat (3) tick();
    checks++;
    if ({count, ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== 13'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got %h/%b expected 00/00000", count,
               {ser_frame, tx_busy, tx_done, ser_clk, ser_data});
    end
    load = 1'b0; tx_start = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [NB-1:0] fr;
    fr = frame_of(8'hA5);
    load = 1'b1; load_val = 8'hA5;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL load_a5 got %h expected a5", count);
    end
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 0; k <= FL + 1; k++) begin
      checks++;
      if ({ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== ser_exp(fr, k)) begin
        failures++;
        $display("[TB] FAIL frame_a5 k=%0d got %b expected %b", k,
                 {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, k));
      end
      if (k <= FL) tick();
    end
    // Start in the first IDLE cycle after DONE must be accepted.
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    checks++;
    if ({ser_frame, tx_busy, ser_data} !== {2'b11, fr[NB-1]}) begin
      failures++;
      $display("[TB] FAIL back_to_back got %b expected %b", {ser_frame, tx_busy, ser_data},
               {2'b11, fr[NB-1]});
    end
    for (int i = 0; i < 200 && tx_busy; i++) tick();
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_timeout got busy=%b expected 0", tx_busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [4] = '{8'h00, 8'hFF, 8'hFE, 8'hFE};
    load = 1'b1; load_val = 8'hFF;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_en = (i < 3);
      up_dn  = (i == 0);
      tick();
      checks++;
      if (count !== exp_v[i]) begin
        failures++;
        $display("[TB] FAIL wrap step=%0d got %h expected %h", i, count, exp_v[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 8'h3C; cnt_en = 1'b1; up_dn = 1'b1;
    tick();
    checks++;
    if (count !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL load_prio_up got %h expected 3c", count);
    end
    load = 1'b0;
    tick();
    checks++;
    if (count !== 8'h3D) begin
      failures++;
      $display("[TB] FAIL count_after_load got %h expected 3d", count);
    end
    load = 1'b1; up_dn = 1'b0;
    tick();
    checks++;
    if (count !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL load_prio_dn got %h expected 3c", count);
    end
    load = 1'b0; cnt_en = 1'b0;
  endtask

  task automatic test_snapshot();
    logic [NB-1:0] fr;
    fr = frame_of(8'h10);
    load = 1'b1; load_val = 8'h10;
    tick();
    load = 1'b0; tx_start = 1'b1; cnt_en = 1'b1; up_dn = 1'b1;
    tick();
    tx_start = 1'b0; cnt_en = 1'b0;
    checks++;
    if (count !== 8'h11) begin
      failures++;
      $display("[TB] FAIL snapshot_count got %h expected 11", count);
    end
    for (int k = 0; k <= FL + 2; k++) begin
      checks++;
      if ({ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== ser_exp(fr, k)) begin
        failures++;
        $display("[TB] FAIL frame_10 k=%0d got %b expected %b", k,
                 {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, k));
      end
      tx_start = (k == 10);
      tick();
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [NB-1:0] fr;
    fr = frame_of(8'h5A);
    load = 1'b1; load_val = 8'h5A;
    tick();
    load = 1'b0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (13) tick();
    checks++;
    if ({ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== ser_exp(fr, 13)) begin
      failures++;
      $display("[TB] FAIL bit3_pre_abort got %b expected %b",
               {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, 13));
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({count, ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== 13'd0) begin
      failures++;
      $display("[TB] FAIL abort_state got %h/%b expected 00/00000", count,
               {ser_frame, tx_busy, tx_done, ser_clk, ser_data});
    end
    rst_n = 1'b1; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    fr = frame_of(8'h00);
    for (int k = 0; k <= FL + 1; k++) begin
      checks++;
      if ({ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== ser_exp(fr, k)) begin
        failures++;
        $display("[TB] FAIL frame_00 k=%0d got %b expected %b", k,
                 {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, k));
      end
      if (k <= FL) tick();
    end
  endtask

  task automatic test_ena_freeze();
    logic [NB-1:0] fr;
    int            ek;
    fr = frame_of(8'hC3);
    load = 1'b1; load_val = 8'hC3;
    tick();
    load = 1'b0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int t = 0; t <= FL + 6; t++) begin
      ek = (t <= 6) ? t : (t <= 11) ? 6 : t - 5;
      checks++;
      if ({count, ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== {8'hC3, ser_exp(fr, ek)}) begin
        failures++;
        $display("[TB] FAIL ena_freeze t=%0d got %h/%b expected c3/%b", t, count,
                 {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, ek));
      end
      if (t == 6) begin ena = 1'b0; cnt_en = 1'b1; up_dn = 1'b1; end
      if (t == 11) begin ena = 1'b1; cnt_en = 1'b0; end
      tick();
    end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] fr;
    fr = frame_of(8'hA4);
    load = 1'b1; load_val = 8'hA4;
    tick();
    load = 1'b0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 0; k <= FL; k++) begin
      checks++;
      if ({ser_frame, tx_busy, tx_done, ser_clk, ser_data} !== ser_exp(fr, k)) begin
        failures++;
        $display("[TB] FAIL parity_a4 k=%0d got %b expected %b", k,
                 {ser_frame, tx_busy, tx_done, ser_clk, ser_data}, ser_exp(fr, k));
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_wrap();
    test_load_priority();
    test_snapshot();
    test_reset_abort();
    test_ena_freeze();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
